preg_update_arbiter: RTL and testbench
======================================

// Module: preg_update_arbiter
// PURPOSE
//  Shares the single write port of the 64-entry pointer register file (12-bit
//  label id + 16-bit offset per entry) among NREQ requesters.
//  Each request is either LOAD (write lbid/ofs) or ADD (read-modify-write:
//  ofs += signed delta, lbid kept).
//  Sits between the execution/loader units and the pointer register file.
//  Owns read port 0 plus the write port; read port 1 stays with the datapath.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  PW     6   pointer index width (64 entries)
//  LW     12  label id width
//  OW     16  offset width; ADD delta is OW-bit two's complement
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  req        in   NREQ     level request per requester; held until its done
//  req_op     in   NREQ     per requester: 0=LOAD, 1=ADD
//  req_p      in   NREQ*PW  target pointer index, requester i at [i*PW +: PW]
//  req_lbid   in   NREQ*LW  LOAD label id (ignored for ADD)
//  req_ofs    in   NREQ*OW  LOAD offset / ADD delta
//  done       out  NREQ     one-cycle pulse: requester i's write committed
//  busy       out  1        FSM not in IDLE
//  p0         out  PW       read index to pointer register file port 0
//  lbid0      in   LW       read data (combinational from file)
//  ofs0       in   OW       read data (combinational from file)
//  pw         out  PW       write index
//  lbidw      out  LW       write label id
//  ofsw       out  OW       write offset
//  we         out  1        write enable; file writes on rising clk when 1
// BEHAVIOUR
//  Reset: state=IDLE, we=0, done=0, busy=0, p0/pw/lbidw/ofsw=0, last=NREQ-1.
//   Reset is asynchronous: an op in flight is abandoned; no write, no done.
//  FSM states: IDLE, RD, WR; all outputs registered.
//  IDLE: if any req, grant the first set bit searching last+1, last+2, ..
//   (mod NREQ). Latch idx, op, p, lbid, ofs. Go to RD if ADD, else WR.
//   No req: stay in IDLE.
//  RD (ADD only): p0=latched p. At the clock edge, capture lbid0 and
//   ofs0+delta (mod 2^OW). Go to WR.
//  WR: we=1, pw=p, lbidw/ofsw=latched or computed values, done[idx]=1 for
//   exactly this cycle; last<=idx; next state is IDLE.
//  Latency from req sampled in IDLE to done/we cycle: LOAD 1 cycle, ADD 2.
//   The file contents update at the end of the WR cycle.
//  Throughput: one op per 2 (LOAD) or 3 (ADD) cycles; IDLE lasts at least
//   one cycle between ops.
//  Requester fields are sampled only at grant; later changes are ignored.
//   A req still high after done is a new request.
//  Fairness: round-robin; a requester waits at most NREQ-1 ops.
//  Same p from back-to-back ops: the second op's RD observes the first
//   op's write, because IDLE intervenes.
//  Dropping req before grant withdraws it; dropping it after grant has no
//   effect.
//  Outputs not driven in a state hold their last value; only we/done pulse.
// CONFIGURATION
//  PREG_ARB_OVF_EN defined:
//   Adds output `ovf` (1 bit), a one-cycle pulse in WR of an ADD whose signed
//   result overflows OW bits (ofs0 and delta same sign, result sign differs).
//   The write still commits with the wrapped value. Reset value is 0.
//  PREG_ARB_OVF_EN undefined: no `ovf` port; ADD wraps silently.
// TESTING
//  LOAD: req[0], p=5, lbid=0x0AB, ofs=0x1234 -> next cycle we=1, pw=5,
//   done[0]=1; read back 0x0AB/0x1234.
//  ADD: entry 5 = (0x0AB, 0x1234); req[2] ADD p=5, delta=0xFFF0 -> done[2]
//   two cycles later, entry 5 = (0x0AB, 0x1224).
//  Round-robin: req=4'b1111 all LOAD, held -> done order 0,1,2,3,0; each
//   done 2 cycles apart.
//  Hazard: req[1] ADD p=9 delta=1, then req[1] ADD p=9 delta=1 again,
//   entry 9 starts at 0x0010 -> final ofs=0x0012.
//  Reset mid-op: assert rst_n=0 during the RD cycle of an ADD -> we and done
//   never pulse; entry unchanged; after release, req[0] is granted first.
//  OVF (PREG_ARB_OVF_EN defined): ofs=0x7FFF, delta=0x0001 -> ovf=1 with
//   done; ofs=0x8000 written.

Source files
------------

// File: rtl/preg_update_arbiter.sv
// Round-robin owner of the pointer register file write port; LOAD commits 1 cycle after grant, ADD 2.
// Requests are level-held until done; optional PREG_ARB_OVF_EN adds the ovf pulse on ADD overflow.
module preg_update_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 6,
   parameter int LW   = 12,
   parameter int OW   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_op,
   input  logic [NREQ*PW-1:0] req_p,
   input  logic [NREQ*LW-1:0] req_lbid,
   input  logic [NREQ*OW-1:0] req_ofs,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [PW-1:0]     p0,
   input  logic [LW-1:0]     lbid0,
   input  logic [OW-1:0]     ofs0,
   output logic [PW-1:0]     pw,
   output logic [LW-1:0]     lbidw,
   output logic [OW-1:0]     ofsw,
   output logic              we
`ifdef PREG_ARB_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [OW-1:0]     delta_q, delta_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;
   logic [PW-1:0]     p0_q, p0_d;
   logic [PW-1:0]     pw_q, pw_d;
   logic [LW-1:0]     lbidw_q, lbidw_d;
   logic [OW-1:0]     ofsw_q, ofsw_d;
   logic              we_q, we_d;
   logic              ovf_q, ovf_d;

   logic              found;
   logic [IW-1:0]     gnt;
   logic [NREQ-1:0]   gnt_oh;
   logic [NREQ-1:0]   idx_oh;
   logic              sel_op;
   logic [PW-1:0]     sel_p;
   logic [LW-1:0]     sel_lbid;
   logic [OW-1:0]     sel_ofs;
   logic [OW-1:0]     sum;
   logic              sum_ovf;

   // Search starts just after the last served requester, wrapping at NREQ.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int            cand;
         logic [IW-1:0] cidx;
         cand = int'(last_q) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         cidx = IW'(cand);
         if (!found && req[cidx]) begin
            found = 1'b1;
            gnt   = cidx;
         end
      end
   end

   always_comb begin
      gnt_oh   = '0;
      idx_oh   = '0;
      sel_op   = 1'b0;
      sel_p    = '0;
      sel_lbid = '0;
      sel_ofs  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt == IW'(i)) begin
            gnt_oh[i] = 1'b1;
            sel_op    = req_op[i];
            sel_p     = req_p[i*PW +: PW];
            sel_lbid  = req_lbid[i*LW +: LW];
            sel_ofs   = req_ofs[i*OW +: OW];
         end
         if (idx_q == IW'(i)) idx_oh[i] = 1'b1;
      end
   end

   assign sum     = ofs0 + delta_q;
   assign sum_ovf = (ofs0[OW-1] == delta_q[OW-1]) && (sum[OW-1] != ofs0[OW-1]);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      delta_d = delta_q;
      p0_d    = p0_q;
      pw_d    = pw_q;
      lbidw_d = lbidw_q;
      ofsw_d  = ofsw_q;
      we_d    = 1'b0;
      done_d  = '0;
      ovf_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               idx_d = gnt;
               if (sel_op) begin
                  p0_d    = sel_p;
                  delta_d = sel_ofs;
                  state_d = RD;
               end else begin
                  pw_d    = sel_p;
                  lbidw_d = sel_lbid;
                  ofsw_d  = sel_ofs;
                  we_d    = 1'b1;
                  done_d  = gnt_oh;
                  state_d = WR;
               end
            end
         end
         RD: begin
            pw_d    = p0_q;
            lbidw_d = lbid0;
            ofsw_d  = sum;
            ovf_d   = sum_ovf;
            we_d    = 1'b1;
            done_d  = idx_oh;
            state_d = WR;
         end
         WR: begin
            last_d  = idx_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= IW'(NREQ - 1);
         idx_q   <= '0;
         delta_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         p0_q    <= '0;
         pw_q    <= '0;
         lbidw_q <= '0;
         ofsw_q  <= '0;
         we_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         delta_q <= delta_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         p0_q    <= p0_d;
         pw_q    <= pw_d;
         lbidw_q <= lbidw_d;
         ofsw_q  <= ofsw_d;
         we_q    <= we_d;
         ovf_q   <= ovf_d;
      end
   end

   assign done  = done_q;
   assign busy  = busy_q;
   assign p0    = p0_q;
   assign pw    = pw_q;
   assign lbidw = lbidw_q;
   assign ofsw  = ofsw_q;
   assign we    = we_q;
`ifdef PREG_ARB_OVF_EN
   assign ovf   = ovf_q;
`else
   // Overflow is still computed so the datapath is identical in both builds.
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_preg_update_arbiter.sv
// Bench for preg_update_arbiter: transaction-level model plus directed scenarios and a register file model.
`timescale 1ns/1ps
module tb_preg_update_arbiter;

   localparam int NREQ = 4;
   localparam int PW   = 6;
   localparam int LW   = 12;
   localparam int OW   = 16;
   localparam int NENT = 1 << PW;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      req_op;
   logic [NREQ*PW-1:0]   req_p;
   logic [NREQ*LW-1:0]   req_lbid;
   logic [NREQ*OW-1:0]   req_ofs;
   logic [NREQ-1:0]      done;
   logic                 busy;
   logic [PW-1:0]        p0;
   logic [LW-1:0]        lbid0;
   logic [OW-1:0]        ofs0;
   logic [PW-1:0]        pw;
   logic [LW-1:0]        lbidw;
   logic [OW-1:0]        ofsw;
   logic                 we;
`ifdef PREG_ARB_OVF_EN
   logic                 ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   preg_update_arbiter #(.NREQ(NREQ), .PW(PW), .LW(LW), .OW(OW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_op   (req_op),
      .req_p    (req_p),
      .req_lbid (req_lbid),
      .req_ofs  (req_ofs),
      .done     (done),
      .busy     (busy),
      .p0       (p0),
      .lbid0    (lbid0),
      .ofs0     (ofs0),
      .pw       (pw),
      .lbidw    (lbidw),
      .ofsw     (ofsw),
      .we       (we)
`ifdef PREG_ARB_OVF_EN
      ,
      .ovf      (ovf)
`endif
   );

   // Pointer register file: combinational read, write on rising edge.
   logic          f_clr;
   logic [LW-1:0] f_lb [NENT];
   logic [OW-1:0] f_of [NENT];
   always @(posedge clk) begin
      if (f_clr) begin
         for (int i = 0; i < NENT; i++) begin
            f_lb[i] <= '0;
            f_of[i] <= '0;
         end
      end else if (we) begin
         f_lb[pw] <= lbidw;
         f_of[pw] <= ofsw;
      end
   end
   assign lbid0 = f_lb[p0];
   assign ofs0  = f_of[p0];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: an op granted at edge g is visible as a commit after edge g+lat,
   // the file takes it one edge later, and a new grant needs one further edge.
   logic [LW-1:0]   m_lb_mem [NENT];
   logic [OW-1:0]   m_of_mem [NENT];
   logic            e_we, e_busy, e_ovf;
   logic [NREQ-1:0] e_done;
   logic [PW-1:0]   e_p0, e_pw;
   logic [LW-1:0]   e_lb;
   logic [OW-1:0]   e_of;

   initial begin
      int last, age, lat, m_idx, g, s;
      bit act, m_ovf;
      logic [PW-1:0] m_p;
      logic [LW-1:0] m_lb;
      logic [OW-1:0] m_of;
      for (int i = 0; i < NENT; i++) begin
         m_lb_mem[i] = '0;
         m_of_mem[i] = '0;
      end
      last = NREQ - 1; act = 0; age = 0; lat = 0; m_idx = 0; m_ovf = 0;
      m_p = '0; m_lb = '0; m_of = '0;
      e_we = 0; e_busy = 0; e_ovf = 0; e_done = '0; e_p0 = '0; e_pw = '0; e_lb = '0; e_of = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            act = 0; last = NREQ - 1;
            e_we = 0; e_busy = 0; e_ovf = 0; e_done = '0;
            e_p0 = '0; e_pw = '0; e_lb = '0; e_of = '0;
         end else begin
            e_we = 0; e_done = '0; e_ovf = 0;
            if (act) age++;
            else if (req != '0) begin
               g = -1;
               for (int k = 1; k <= NREQ; k++)
                  if (g < 0 && req[(last + k) % NREQ]) g = (last + k) % NREQ;
               m_idx = g;
               m_p   = req_p[g*PW +: PW];
               if (req_op[g]) begin
                  m_lb  = m_lb_mem[m_p];
                  s     = int'($signed(m_of_mem[m_p])) + int'($signed(req_ofs[g*OW +: OW]));
                  m_of  = OW'(s);
                  m_ovf = (s >= (1 << (OW-1))) || (s < -(1 << (OW-1)));
                  lat   = 1;
                  e_p0  = m_p;
               end else begin
                  m_lb  = req_lbid[g*LW +: LW];
                  m_of  = req_ofs[g*OW +: OW];
                  m_ovf = 0;
                  lat   = 0;
               end
               act = 1; age = 0;
            end
            if (act) begin
               e_busy = 1;
               if (age == lat) begin
                  e_we = 1; e_done[m_idx] = 1'b1;
                  e_pw = m_p; e_lb = m_lb; e_of = m_of; e_ovf = m_ovf;
               end else if (age == lat + 1) begin
                  act = 0; e_busy = 0;
                  m_lb_mem[m_p] = m_lb;
                  m_of_mem[m_p] = m_of;
                  last = m_idx;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("we", 32'(we), 32'(e_we));
         chk("done", 32'(done), 32'(e_done));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("p0", 32'(p0), 32'(e_p0));
         chk("pw", 32'(pw), 32'(e_pw));
         chk("lbidw", 32'(lbidw), 32'(e_lb));
         chk("ofsw", 32'(ofsw), 32'(e_of));
`ifdef PREG_ARB_OVF_EN
         chk("ovf", 32'(ovf), 32'(e_ovf));
`endif
      end
   end

   task automatic set_req(input int i, input bit add, input int p, input int lb, input int of);
      req_op[i]              = add;
      req_p[i*PW +: PW]      = PW'(p);
      req_lbid[i*LW +: LW]   = LW'(lb);
      req_ofs[i*OW +: OW]    = OW'(of);
   endtask

   // Raise one request, measure cycles to its done, drop it in the commit cycle.
   task automatic run_op(input int i, input bit add, input int p, input int lb, input int of,
                         input int exp_lat, input string nm);
      int n;
      bit seen;
      @(negedge clk);
      set_req(i, add, p, lb, of);
      req[i] = 1'b1;
      n = 0; seen = 0;
      while (!seen && n < 10) begin
         @(posedge clk);
         #1;
         n++;
         if (done[i]) seen = 1;
      end
      chk({nm, "_lat"}, seen ? n : 99, exp_lat);
      @(negedge clk);
      req[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int order[$];
      int stamp[$];
      int cyc, n, first;
      rst_n = 1'b0; f_clr = 1'b1;
      req = '0; req_op = '0; req_p = '0; req_lbid = '0; req_ofs = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pw", 32'(pw), 0);
      rst_n = 1'b1; f_clr = 1'b0;
      idle(2);

      run_op(0, 1'b0, 5, 'h0AB, 'h1234, 1, "load");
      chk("load_pw", 32'(pw), 5);
      idle(2);
      chk("load_lb", 32'(f_lb[5]), 'h0AB);
      chk("load_of", 32'(f_of[5]), 'h1234);

      run_op(2, 1'b1, 5, 0, 'hFFF0, 2, "add");
      idle(2);
      chk("add_lb", 32'(f_lb[5]), 'h0AB);
      chk("add_of", 32'(f_of[5]), 'h1224);

      run_op(3, 1'b0, 20, 'h020, 'h0020, 1, "pre_rr");
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 10 + i, 'h100 + i, 'h200 + i);
      req = '1;
      cyc = 0;
      while (order.size() < 5 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done != '0) begin
            chk("rr_onehot", 32'($countones(done)), 1);
            for (int i = 0; i < NREQ; i++) if (done[i]) order.push_back(i);
            stamp.push_back(cyc);
         end
      end
      @(negedge clk);
      req = '0;
      chk("rr_count", 32'(order.size()), 5);
      if (order.size() == 5) begin
         chk("rr_0", 32'(order[0]), 0);
         chk("rr_1", 32'(order[1]), 1);
         chk("rr_2", 32'(order[2]), 2);
         chk("rr_3", 32'(order[3]), 3);
         chk("rr_4", 32'(order[4]), 0);
         chk("rr_first", 32'(stamp[0]), 1);
         for (int i = 1; i < 5; i++) chk("rr_gap", 32'(stamp[i] - stamp[i-1]), 2);
      end
      idle(2);
      chk("rr_file", 32'(f_of[13]), 'h203);

      run_op(1, 1'b0, 9, 'h055, 'h0010, 1, "haz_load");
      run_op(1, 1'b1, 9, 0, 1, 2, "haz_add1");
      run_op(1, 1'b1, 9, 0, 1, 2, "haz_add2");
      idle(2);
      chk("haz_of", 32'(f_of[9]), 'h0012);
      chk("haz_lb", 32'(f_lb[9]), 'h055);

      @(negedge clk);
      set_req(2, 1'b1, 9, 0, 'h0100);
      req[2] = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_busy", 32'(busy), 1);
      chk("mid_p0", 32'(p0), 9);
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("mid_we", 32'(we), 0);
         chk("mid_done", 32'(done), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("mid_of", 32'(f_of[9]), 'h0012);
      set_req(0, 1'b0, 30, 'h030, 'h3000);
      set_req(2, 1'b0, 31, 'h031, 'h3100);
      req = 4'b0101;
      n = 0; first = -1;
      while (first < 0 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
         if (done != '0) first = int'(done);
      end
      chk("post_rst_first", 32'(first), 'b0001);
      @(negedge clk);
      req[0] = 1'b0;
      n = 0;
      while (!done[2] && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("post_rst_second", 32'(done), 'b0100);
      @(negedge clk);
      req = '0;
      idle(2);
      chk("post_rst_of", 32'(f_of[31]), 'h3100);

      run_op(3, 1'b0, 40, 'h077, 'h7FFF, 1, "ovf_load");
      run_op(3, 1'b1, 40, 0, 1, 2, "ovf_add");
`ifdef PREG_ARB_OVF_EN
      chk("ovf_pulse", 32'(ovf), 1);
`endif
      idle(2);
      chk("ovf_of", 32'(f_of[40]), 'h8000);
      chk("ovf_lb", 32'(f_lb[40]), 'h077);

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
